beam_mac_sched: RTL

//  Time-multiplexes one pipelined complex multiplier across NUM_CH antenna channels to form a single beam sample.
//  The beam sample is y = sum_k conj?(w_k) * x_k.

---
 rtl/beam_mac_sched_pkg.sv | 37 +++
 rtl/beam_mac_sched_cmul.sv | 63 ++++++
 rtl/beam_mac_sched.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/beam_mac_sched_pkg.sv
// Shared definitions for the beamformer MAC scheduler: default widths,
// accumulator width helper, unity weight constant, FSM encoding and the
// output saturation helper.
package bf_pkg;

    localparam int DW_DEF   = 18;
    localparam int FRAC_DEF = 15;
    localparam int ONE_Q    = 2 ** FRAC_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Width that holds NUM_CH shifted products without ever wrapping.
    function automatic int acc_w(input int dw, input int frac, input int nch);
        return 2 * dw - frac + $clog2(nch) + 1;
    endfunction

    // Clamp a sign-extended value to the signed range of a dw-bit word.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/beam_mac_sched_cmul.sv
// Registered complex multiplier. Forms w*x or conj(w)*x at full precision,
// drops FRAC fractional bits with an arithmetic shift (floor) and presents
// the result sign-extended to ACC_W bits one cycle later.
module cmul_pipe #(
    parameter int DW    = 18,
    parameter int FRAC  = 15,
    parameter int ACC_W = 24,
    parameter int CONJ  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DW-1:0]    x_i,
    input  logic [DW-1:0]    x_q,
    input  logic [DW-1:0]    w_i,
    input  logic [DW-1:0]    w_q,
    output logic [ACC_W-1:0] p_i,
    output logic [ACC_W-1:0] p_q
);

    // One extra bit over 2*DW: the sum of two full-scale products
    // (e.g. (-1)*(-1) + (-1)*(-1)) needs it.
    localparam int PW = 2 * DW + 1;

    logic signed [PW-1:0] xi_e;
    logic signed [PW-1:0] xq_e;
    logic signed [PW-1:0] wi_e;
    logic signed [PW-1:0] wq_e;
    logic signed [PW-1:0] re_full;
    logic signed [PW-1:0] im_full;
    logic signed [PW-1:0] re_sh;
    logic signed [PW-1:0] im_sh;

    assign xi_e = PW'($signed(x_i));
    assign xq_e = PW'($signed(x_q));
    assign wi_e = PW'($signed(w_i));
    assign wq_e = PW'($signed(w_q));

    generate
        if (CONJ != 0) begin : g_conj
            assign re_full = wi_e * xi_e + wq_e * xq_e;
            assign im_full = wi_e * xq_e - wq_e * xi_e;
        end else begin : g_plain
            assign re_full = wi_e * xi_e - wq_e * xq_e;
            assign im_full = wi_e * xq_e + wq_e * xi_e;
        end
    endgenerate

    assign re_sh = re_full >>> FRAC;
    assign im_sh = im_full >>> FRAC;

    // Product register, advanced only while a channel is being issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_i <= '0;
            p_q <= '0;
        end else if (en) begin
            p_i <= ACC_W'(re_sh);
            p_q <= ACC_W'(im_sh);
        end
    end

endmodule

// File: rtl/beam_mac_sched.sv
// Beam MAC scheduler: accepts one vector of NUM_CH IQ samples, walks the
// channels through a single pipelined complex multiplier, accumulates
// without wrap and emits one saturated beam sample per vector.
module beam_mac_sched
    import bf_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DW     = DW_DEF,
    parameter int FRAC   = FRAC_DEF,
    parameter int CONJ_W = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DW-1:0]     in_i,
    input  logic [NUM_CH*DW-1:0]     in_q,
    input  logic                     w_we,
    input  logic [$clog2(NUM_CH)-1:0] w_addr,
    input  logic [DW-1:0]            w_i,
    input  logic [DW-1:0]            w_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_i,
    output logic [DW-1:0]            out_q,
    output logic                     sat_flag,
    output logic                     busy
);

    localparam int AW    = $clog2(NUM_CH);
    localparam int ACC_W = acc_w(DW, FRAC, NUM_CH);
    localparam logic [DW-1:0] ONE_W = DW'(2 ** FRAC);

    state_t                    state_reg;
    logic [AW-1:0]             idx_reg;
    logic signed [ACC_W-1:0]   acc_i_reg;
    logic signed [ACC_W-1:0]   acc_q_reg;
    logic [DW-1:0]             out_i_reg;
    logic [DW-1:0]             out_q_reg;
    logic                      out_valid_reg;
    logic                      in_ready_reg;
    logic                      busy_reg;
    logic                      sat_flag_reg;

    // Per-channel views of the latched vector and the shadow weights.
    logic [NUM_CH-1:0][DW-1:0] x_i_pk;
    logic [NUM_CH-1:0][DW-1:0] x_q_pk;
    logic [NUM_CH-1:0][DW-1:0] ws_i_pk;
    logic [NUM_CH-1:0][DW-1:0] ws_q_pk;

    logic                      accept;
    logic                      mul_en;
    logic [ACC_W-1:0]          prod_i;
    logic [ACC_W-1:0]          prod_q;
    logic signed [ACC_W-1:0]   sum_i_next;
    logic signed [ACC_W-1:0]   sum_q_next;
    logic signed [63:0]        sum_i64;
    logic signed [63:0]        sum_q64;
    logic signed [63:0]        sat_i64;
    logic signed [63:0]        sat_q64;

    assign accept = (state_reg == ST_IDLE) && in_valid;
    assign mul_en = (state_reg == ST_MAC);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DW-1:0] wl_i_reg;
            logic [DW-1:0] wl_q_reg;
            logic [DW-1:0] ws_i_reg;
            logic [DW-1:0] ws_q_reg;
            logic [DW-1:0] x_i_reg;
            logic [DW-1:0] x_q_reg;

            // Live weight: only an address matching this channel writes, so
            // out-of-range addresses fall through harmlessly.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wl_i_reg <= ONE_W;
                    wl_q_reg <= '0;
                end else if (w_we && (int'(w_addr) == gi)) begin
                    wl_i_reg <= w_i;
                    wl_q_reg <= w_q;
                end
            end

            // Snapshot weight and sample at accept; a same-edge weight
            // write lands in the live file only.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ws_i_reg <= ONE_W;
                    ws_q_reg <= '0;
                    x_i_reg  <= '0;
                    x_q_reg  <= '0;
                end else if (accept) begin
                    ws_i_reg <= wl_i_reg;
                    ws_q_reg <= wl_q_reg;
                    x_i_reg  <= in_i[gi*DW +: DW];
                    x_q_reg  <= in_q[gi*DW +: DW];
                end
            end

            assign ws_i_pk[gi] = ws_i_reg;
            assign ws_q_pk[gi] = ws_q_reg;
            assign x_i_pk[gi]  = x_i_reg;
            assign x_q_pk[gi]  = x_q_reg;
        end
    endgenerate

    cmul_pipe #(
        .DW    (DW),
        .FRAC  (FRAC),
        .ACC_W (ACC_W),
        .CONJ  (CONJ_W)
    ) u_cmul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mul_en),
        .x_i   (x_i_pk[idx_reg]),
        .x_q   (x_q_pk[idx_reg]),
        .w_i   (ws_i_pk[idx_reg]),
        .w_q   (ws_q_pk[idx_reg]),
        .p_i   (prod_i),
        .p_q   (prod_q)
    );

    assign sum_i_next = acc_i_reg + $signed(prod_i);
    assign sum_q_next = acc_q_reg + $signed(prod_q);
    assign sum_i64    = 64'(sum_i_next);
    assign sum_q64    = 64'(sum_q_next);
    assign sat_i64    = sat(sum_i64, DW);
    assign sat_q64    = sat(sum_q64, DW);

    // Sequencer: accept, issue channels, drain the last product, hold output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            acc_i_reg     <= '0;
            acc_q_reg     <= '0;
            out_i_reg     <= '0;
            out_q_reg     <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            sat_flag_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc_i_reg    <= '0;
                        acc_q_reg    <= '0;
                        idx_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    // The product register holds a stale value while idx=0.
                    if (idx_reg != '0) begin
                        acc_i_reg <= sum_i_next;
                        acc_q_reg <= sum_q_next;
                    end
                    if (idx_reg == AW'(NUM_CH - 1)) begin
                        state_reg <= ST_DRAIN;
                    end else begin
                        idx_reg <= idx_reg + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    acc_i_reg     <= sum_i_next;
                    acc_q_reg     <= sum_q_next;
                    out_i_reg     <= sat_i64[DW-1:0];
                    out_q_reg     <= sat_q64[DW-1:0];
                    sat_flag_reg  <= (sat_i64 != sum_i64) || (sat_q64 != sum_q64);
                    out_valid_reg <= 1'b1;
                    state_reg     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_i     = out_i_reg;
    assign out_q     = out_q_reg;
    assign sat_flag  = sat_flag_reg;
    assign busy      = busy_reg;

endmodule
